// File: rtl/multicycle_seq_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory side.
// master: the sequencer (drives strobes, observes opcode/flags/ack).
// slave:  the datapath and memory (drives opcode/flags/ack, observes strobes).
interface multicycle_seq_ctrl_if;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_sel;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src;
  logic       retire;
  logic       trap;
  logic [2:0] state;

  modport master (
    input  opcode, zero, mem_ack,
    output mem_req, mem_sel, mem_we, ir_write, pc_write, pc_src,
           reg_write, reg_dst, alu_src, retire, trap, state
  );

  modport slave (
    output opcode, zero, mem_ack,
    input  mem_req, mem_sel, mem_we, ir_write, pc_write, pc_src,
           reg_write, reg_dst, alu_src, retire, trap, state
  );
endinterface

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer for the 4-bit-opcode core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port (req/ack) and traps on illegal opcodes or a stalled access.
//
// state  | meaning
// IDLE   | out of reset, no strobes, leaves on the first clock
// FETCH  | instruction read at PC; IR/PC update on ack
// DECODE | one cycle for opcode classification
// EXEC   | ALU operation, branch resolution
// MEM    | data read/write at ALU result
// WB     | register-file write, retire
// TRAP   | sticky error, only reset leaves (code 6 also lands here)
module multicycle_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_seq_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_RSVD   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  // The counter value seen during the last allowed un-acked request cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;

  logic is_load, is_store, is_stri, is_boz, is_bran, is_alu, is_illegal;
  logic to_hit;

  logic mem_req, mem_sel, mem_we, ir_write, pc_write, pc_src;
  logic reg_write, reg_dst, alu_src, retire, trap;

  assign is_load    = (bus.opcode == 4'b0000);
  assign is_store   = (bus.opcode == 4'b0010);
  assign is_stri    = (bus.opcode == 4'b0100);
  assign is_boz     = (bus.opcode == 4'b0110);
  assign is_bran    = (bus.opcode == 4'b1000);
  assign is_alu     = bus.opcode[0];
  assign is_illegal = (bus.opcode == 4'b1100) || (bus.opcode == 4'b1110);

  // An un-acked request in this cycle would push the count to MEM_TIMEOUT.
  assign to_hit = (to_q == TO_LAST) && !bus.mem_ack;

  // State and timeout registers; reset drops state to IDLE, which zeroes every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
    end
  end

  // Next-state and strobe decode from state, opcode, zero and mem_ack.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    alu_src   = 1'b0;
    retire    = 1'b0;
    trap      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: state_d = is_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        alu_src = is_load || is_store || is_stri;
        if (is_bran) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_boz) begin
          pc_write = bus.zero;
          pc_src   = bus.zero;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        alu_src = 1'b1;
        mem_we  = is_store;
        if (bus.mem_ack) begin
          retire  = is_store;
          state_d = is_store ? S_FETCH : S_WB;
        end else if (to_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = !(is_load || is_stri);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

  // Timeout count of un-acked request cycles; restarts on ack or any state change.
  always_comb begin
    to_d = to_q;
    if ((state_d != state_q) || bus.mem_ack) begin
      to_d = '0;
    end else if (mem_req) begin
      to_d = to_q + TO_W'(1);
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_sel   = mem_sel;
  assign bus.mem_we    = mem_we;
  assign bus.ir_write  = ir_write;
  assign bus.pc_write  = pc_write;
  assign bus.pc_src    = pc_src;
  assign bus.reg_write = reg_write;
  assign bus.reg_dst   = reg_dst;
  assign bus.alu_src   = alu_src;
  assign bus.retire    = retire;
  assign bus.trap      = trap;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Directed bench for the multi-cycle sequencer: reset, each opcode class,
// ack stalls, memory timeout, illegal-opcode trap and async reset mid-access.
module tb_multicycle_seq_ctrl;

  // Output vector order: mem_req mem_sel mem_we ir_write pc_write pc_src
  //                      reg_write reg_dst alu_src retire trap
  localparam logic [10:0] O_NONE      = 11'b00000000000;
  localparam logic [10:0] O_FETCH_ACK = 11'b10011000000;
  localparam logic [10:0] O_FETCH_WT  = 11'b10000000000;
  localparam logic [10:0] O_EXEC_IMM  = 11'b00000000100;
  localparam logic [10:0] O_MEM_LD    = 11'b11000000100;
  localparam logic [10:0] O_MEM_ST    = 11'b11100000110;
  localparam logic [10:0] O_WB_RT     = 11'b00000010010;
  localparam logic [10:0] O_WB_RD     = 11'b00000011010;
  localparam logic [10:0] O_BR_TAKEN  = 11'b00001100010;
  localparam logic [10:0] O_RET_ONLY  = 11'b00000000010;
  localparam logic [10:0] O_TRAP      = 11'b00000000001;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  multicycle_seq_ctrl_if bus();

  multicycle_seq_ctrl #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {bus.mem_req, bus.mem_sel, bus.mem_we, bus.ir_write, bus.pc_write,
            bus.pc_src, bus.reg_write, bus.reg_dst, bus.alu_src, bus.retire, bus.trap};
  endfunction

  // Reset with inputs preset, release on a falling edge; cycle 0 (IDLE) follows.
  task automatic do_reset(input logic [3:0] op, input logic ack, input logic z);
    rst_n = 1'b0;
    bus.opcode  = op;
    bus.mem_ack = ack;
    bus.zero    = z;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = 4'b0001; bus.mem_ack = 1'b1; bus.zero = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_cmp++; if (outs() !== O_NONE) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs(), O_NONE); end
    do_reset(4'b0001, 1'b1, 1'b0);
    #1;
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL release_idle: got %0d want 0", bus.state); end
    @(negedge clk); #1;
    n_cmp++; if (bus.state !== 3'd1) begin n_bad++; $display("FAIL release_fetch_state: got %0d want 1", bus.state); end
    n_cmp++; if (outs() !== O_FETCH_ACK) begin n_bad++; $display("FAIL release_fetch_outs: got %b want %b", outs(), O_FETCH_ACK); end
  endtask

  task automatic test_alu_back_to_back();
    logic [2:0]  es [9];
    logic [10:0] eo [9];
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd5};
    eo = '{O_NONE, O_FETCH_ACK, O_NONE, O_NONE, O_WB_RD, O_FETCH_ACK, O_NONE, O_NONE, O_WB_RD};
    do_reset(4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      #1;
      n_cmp++; if (bus.state !== es[i]) begin n_bad++; $display("FAIL alu_state[%0d]: got %0d want %0d", i, bus.state, es[i]); end
      n_cmp++; if (outs() !== eo[i]) begin n_bad++; $display("FAIL alu_outs[%0d]: got %b want %b", i, outs(), eo[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_load_stall();
    logic [2:0]  es [10];
    logic [10:0] eo [10];
    logic        ak [10];
    es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
    eo = '{O_NONE, O_FETCH_ACK, O_NONE, O_EXEC_IMM, O_MEM_LD, O_MEM_LD, O_MEM_LD,
           O_MEM_LD, O_WB_RT, O_FETCH_ACK};
    ak = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.mem_ack = ak[i];
      #1;
      n_cmp++; if (bus.state !== es[i]) begin n_bad++; $display("FAIL load_state[%0d]: got %0d want %0d", i, bus.state, es[i]); end
      n_cmp++; if (outs() !== eo[i]) begin n_bad++; $display("FAIL load_outs[%0d]: got %b want %b", i, outs(), eo[i]); end
      @(negedge clk);
    end
  endtask

  // Store, stri and comp with zero-wait ack: cycles 3.. after reset release.
  task automatic test_classes();
    logic [3:0]  op [3];
    logic [2:0]  es [3][3];
    logic [10:0] eo [3][3];
    op    = '{4'b0010, 4'b0100, 4'b1010};
    es[0] = '{3'd3, 3'd4, 3'd1}; eo[0] = '{O_EXEC_IMM, O_MEM_ST, O_FETCH_ACK};
    es[1] = '{3'd3, 3'd5, 3'd1}; eo[1] = '{O_EXEC_IMM, O_WB_RT,  O_FETCH_ACK};
    es[2] = '{3'd3, 3'd5, 3'd1}; eo[2] = '{O_NONE,     O_WB_RD,  O_FETCH_ACK};
    for (int k = 0; k < 3; k++) begin
      do_reset(op[k], 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        #1;
        n_cmp++; if (bus.state !== es[k][i]) begin n_bad++; $display("FAIL class%0d_state[%0d]: got %0d want %0d", k, i, bus.state, es[k][i]); end
        n_cmp++; if (outs() !== eo[k][i]) begin n_bad++; $display("FAIL class%0d_outs[%0d]: got %b want %b", k, i, outs(), eo[k][i]); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_branches();
    logic [3:0]  op [3];
    logic        zv [3];
    logic [10:0] ex [3];
    op = '{4'b0110, 4'b0110, 4'b1000};
    zv = '{1'b1, 1'b0, 1'b0};
    ex = '{O_BR_TAKEN, O_RET_ONLY, O_BR_TAKEN};
    for (int k = 0; k < 3; k++) begin
      do_reset(op[k], 1'b1, zv[k]);
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (bus.state !== 3'd3) begin n_bad++; $display("FAIL br%0d_exec_state: got %0d want 3", k, bus.state); end
      n_cmp++; if (outs() !== ex[k]) begin n_bad++; $display("FAIL br%0d_exec_outs: got %b want %b", k, outs(), ex[k]); end
      @(negedge clk); #1;
      n_cmp++; if (bus.state !== 3'd1) begin n_bad++; $display("FAIL br%0d_next_fetch: got %0d want 1", k, bus.state); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    int bad_cycles;
    do_reset(4'b1110, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.state !== 3'd2) begin n_bad++; $display("FAIL illegal_decode: got %0d want 2", bus.state); end
    n_cmp++; if (bus.retire !== 1'b0) begin n_bad++; $display("FAIL illegal_decode_retire: got %b want 0", bus.retire); end
    @(negedge clk);
    bad_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      bus.mem_ack = 1'($urandom_range(0, 1));
      bus.zero    = 1'($urandom_range(0, 1));
      #1;
      if (bus.state !== 3'd7 || outs() !== O_TRAP) begin
        bad_cycles++;
        $display("FAIL trap_hold[%0d]: got state %0d outs %b want 7 %b", i, bus.state, outs(), O_TRAP);
      end
      @(negedge clk);
    end
    n_cmp++; if (bad_cycles != 0) n_bad++;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL trap_reset_state: got %0d want 0", bus.state); end
    n_cmp++; if (outs() !== O_NONE) begin n_bad++; $display("FAIL trap_reset_outs: got %b want %b", outs(), O_NONE); end
    do_reset(4'b1100, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (outs() !== O_TRAP) begin n_bad++; $display("FAIL illegal_1100: got %b want %b", outs(), O_TRAP); end
  endtask

  task automatic test_timeout();
    int bad_cycles;
    do_reset(4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    bad_cycles = 0;
    for (int i = 1; i <= 15; i++) begin
      #1;
      if (bus.state !== 3'd1 || outs() !== O_FETCH_WT) begin
        bad_cycles++;
        $display("FAIL to_fetch_wait[%0d]: got state %0d outs %b want 1 %b", i, bus.state, outs(), O_FETCH_WT);
      end
      @(negedge clk);
    end
    n_cmp++; if (bad_cycles != 0) n_bad++;
    #1;
    n_cmp++; if (bus.state !== 3'd7) begin n_bad++; $display("FAIL to_fetch_trap: got %0d want 7", bus.state); end
    n_cmp++; if (bus.trap !== 1'b1) begin n_bad++; $display("FAIL to_fetch_trap_flag: got %b want 1", bus.trap); end

    do_reset(4'b0001, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    bus.mem_ack = 1'b1;
    #1;
    n_cmp++; if (outs() !== O_FETCH_ACK) begin n_bad++; $display("FAIL to_ack_wins_outs: got %b want %b", outs(), O_FETCH_ACK); end
    @(negedge clk); #1;
    n_cmp++; if (bus.state !== 3'd2) begin n_bad++; $display("FAIL to_ack_wins_state: got %0d want 2", bus.state); end

    do_reset(4'b0010, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    bus.mem_ack = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    n_cmp++; if (bus.state !== 3'd4) begin n_bad++; $display("FAIL to_mem_last: got %0d want 4", bus.state); end
    @(negedge clk); #1;
    n_cmp++; if (bus.state !== 3'd7) begin n_bad++; $display("FAIL to_mem_trap: got %0d want 7", bus.state); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset(4'b0000, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.state !== 3'd4) begin
      n_bad++; $display("FAIL midmem_req: got req %b state %0d want 1 4", bus.mem_req, bus.state);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_bad++; $display("FAIL midmem_drop: got %b want 0", bus.mem_req); end
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL midmem_state: got %0d want 0", bus.state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.opcode = 4'b0000; bus.mem_ack = 1'b0; bus.zero = 1'b0;
    test_reset();
    test_alu_back_to_back();
    test_load_stall();
    test_classes();
    test_branches();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
